// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: loads a KEY_SIZE-bit key, then XORs a MSG_SIZE-bit message beat by beat.
// Ciphertext is registered, so each output beat trails its input beat by exactly one cycle.
module xor_stream_cipher #(
  parameter int unsigned KEY_SIZE = 32,
  parameter int unsigned MSG_SIZE = 512,
  parameter int unsigned WIDTH    = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iData,
  input  logic             iLoad_key,
  input  logic             iLoad_msg,
  input  logic             iMode_roll,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  output logic             oStart,
  output logic             oEnd,
  output logic             oKey_ready,
  output logic             oBusy
);

  localparam int unsigned KB  = KEY_SIZE / WIDTH;
  localparam int unsigned MB  = MSG_SIZE / WIDTH;
  localparam int unsigned KCW = $clog2(KB) + 1;
  localparam int unsigned MCW = $clog2(MB) + 1;

  localparam logic [KCW-1:0] KbLast = KCW'(KB - 1);
  localparam logic [MCW-1:0] MbLast = MCW'(MB - 1);

  typedef enum logic [1:0] {StIdle, StKey, StReady, StStream} stateT;

  stateT stateQ, stateD;

  logic [KEY_SIZE-1:0] keyRegQ, keyRegD;
  logic [KEY_SIZE-1:0] workKeyQ, workKeyD;
  logic                rollQ, rollD;
  logic                keyReadyQ, keyReadyD;
  logic [KCW-1:0]      keyCntQ, keyCntD;
  logic [KCW-1:0]      kIdxQ, kIdxD;
  logic [MCW-1:0]      msgCntQ, msgCntD;
  logic [WIDTH-1:0]    dataQ, dataD;
  logic                validQ, validD;
  logic                startQ, startD;
  logic                endQ, endD;

  logic                keyBeat, msgBeat;
  logic                keyAccept, msgAccept, firstBeat;
  logic [KEY_SIZE-1:0] curKey;
  logic                curRoll;
  logic [KCW-1:0]      kCur, keyBase;
  logic [MCW-1:0]      mCur;
  logic [WIDTH-1:0]    keySlice;

  assign keyBeat = iEn & iLoad_key;
  assign msgBeat = iEn & iLoad_msg;

  // State register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (keyBeat) stateD = (KB == 1) ? StReady : StKey;
      end
      StKey: begin
        if (keyBeat) begin
          if (keyCntQ == KbLast) stateD = StReady;
        end else if (iEn) begin
          stateD = StIdle;
        end
      end
      StReady: begin
        if (keyBeat) begin
          stateD = (KB == 1) ? StReady : StKey;
        end else if (msgBeat) begin
          stateD = (MB == 1) ? StReady : StStream;
        end
      end
      StStream: begin
        if (msgBeat) begin
          if (msgCntQ == MbLast) stateD = StReady;
        end else if (iEn) begin
          stateD = StReady;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  // Key and message datapath next-state.
  always_comb begin
    keyRegD   = keyRegQ;
    workKeyD  = workKeyQ;
    rollD     = rollQ;
    keyReadyD = keyReadyQ;
    keyCntD   = keyCntQ;
    kIdxD     = kIdxQ;
    msgCntD   = msgCntQ;
    dataD     = '0;
    validD    = 1'b0;
    startD    = 1'b0;
    endD      = 1'b0;

    // Key wins over message outside STREAM; inside STREAM the key flag is ignored.
    keyAccept = keyBeat && (stateQ != StStream);
    msgAccept = msgBeat && ((stateQ == StReady && !iLoad_key) || stateQ == StStream);
    firstBeat = (stateQ == StReady);

    curKey  = firstBeat ? keyRegQ : workKeyQ;
    curRoll = firstBeat ? iMode_roll : rollQ;
    kCur    = firstBeat ? '0 : kIdxQ;
    mCur    = firstBeat ? '0 : msgCntQ;
    keyBase = (stateQ == StKey) ? keyCntQ : '0;

    keySlice = '0;
    for (int unsigned i = 0; i < KB; i++) begin
      if (kCur == KCW'(i)) keySlice = curKey[KEY_SIZE-1-i*WIDTH -: WIDTH];
    end

    if (keyAccept) begin
      keyRegD = (keyRegQ << WIDTH) | KEY_SIZE'(iData);
      if (keyBase == KbLast) begin
        keyCntD   = '0;
        keyReadyD = 1'b1;
      end else begin
        keyCntD   = keyBase + KCW'(1);
        keyReadyD = 1'b0;
      end
    end else if (stateQ == StKey && iEn) begin
      keyCntD = '0;
    end

    if (msgAccept) begin
      dataD  = iData ^ keySlice;
      validD = 1'b1;
      startD = firstBeat;
      endD   = (mCur == MbLast);
      rollD  = curRoll;
      if (kCur == KbLast) begin
        kIdxD    = '0;
        workKeyD = curRoll ? ((curKey << 1) | (curKey >> (KEY_SIZE - 1))) : curKey;
      end else begin
        kIdxD    = kCur + KCW'(1);
        workKeyD = curKey;
      end
      msgCntD = (mCur == MbLast) ? '0 : mCur + MCW'(1);
    end else if (stateQ == StStream && iEn) begin
      msgCntD = '0;
      kIdxD   = '0;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      keyRegQ   <= '0;
      workKeyQ  <= '0;
      rollQ     <= 1'b0;
      keyReadyQ <= 1'b0;
      keyCntQ   <= '0;
      kIdxQ     <= '0;
      msgCntQ   <= '0;
      dataQ     <= '0;
      validQ    <= 1'b0;
      startQ    <= 1'b0;
      endQ      <= 1'b0;
    end else begin
      keyRegQ   <= keyRegD;
      workKeyQ  <= workKeyD;
      rollQ     <= rollD;
      keyReadyQ <= keyReadyD;
      keyCntQ   <= keyCntD;
      kIdxQ     <= kIdxD;
      msgCntQ   <= msgCntD;
      dataQ     <= dataD;
      validQ    <= validD;
      startQ    <= startD;
      endQ      <= endD;
    end
  end

  // Outputs.
  always_comb begin
    oData      = dataQ;
    oValid     = validQ;
    oStart     = startQ;
    oEnd       = endQ;
    oKey_ready = keyReadyQ;
    oBusy      = (stateQ == StStream);
  end

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed bench for xor_stream_cipher with an 8-bit key, 32-bit message and 4-bit beats.
module tb_xor_stream_cipher;

  logic       iClk, iRst, iEn, iLoad_key, iLoad_msg, iMode_roll;
  logic [3:0] iData;
  logic [3:0] oData;
  logic       oValid, oStart, oEnd, oKey_ready, oBusy;

  int checks = 0;
  int errors = 0;

  xor_stream_cipher #(
    .KEY_SIZE(8),
    .MSG_SIZE(32),
    .WIDTH   (4)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iEn       (iEn),
    .iData     (iData),
    .iLoad_key (iLoad_key),
    .iLoad_msg (iLoad_msg),
    .iMode_roll(iMode_roll),
    .oData     (oData),
    .oValid    (oValid),
    .oStart    (oStart),
    .oEnd      (oEnd),
    .oKey_ready(oKey_ready),
    .oBusy     (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
  task automatic step(input logic en, input logic lk, input logic lm, input logic roll,
                      input logic [3:0] d);
    iEn = en; iLoad_key = lk; iLoad_msg = lm; iMode_roll = roll; iData = d;
    @(posedge iClk);
    #1;
  endtask

  task automatic loadKey(input logic [7:0] k);
    step(1'b1, 1'b1, 1'b0, 1'b0, k[7:4]);
    check("key_half_ready", oKey_ready, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, k[3:0]);
    check("key_full_ready", oKey_ready, 1);
  endtask

  // Send a full message; gaps[i] inserts an idle cycle before beat i, keyToo raises
  // iLoad_key alongside iLoad_msg from beat 1 onward.
  task automatic sendMsg(input logic [31:0] pt, input logic [31:0] ct, input logic roll,
                         input logic [7:0] gaps, input logic keyToo);
    for (int i = 0; i < 8; i++) begin
      if (gaps[i]) begin
        step(1'b0, 1'b0, 1'b0, roll, 4'h0);
        check("gap_valid", oValid, 0);
      end
      step(1'b1, keyToo && (i > 0), 1'b1, roll, pt[31-4*i -: 4]);
      check("beat_valid", oValid, 1);
      check("beat_data", oData, ct[31-4*i -: 4]);
      check("beat_start", oStart, (i == 0) ? 1 : 0);
      check("beat_end", oEnd, (i == 7) ? 1 : 0);
      check("beat_busy", oBusy, (i == 7) ? 0 : 1);
    end
  endtask

  initial begin
    iRst = 1'b0; iEn = 1'b0; iLoad_key = 1'b0; iLoad_msg = 1'b0; iMode_roll = 1'b0;
    iData = 4'h0;
    #2 iRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    check("rst_data", oData, 0);
    check("rst_valid", oValid, 0);
    check("rst_start", oStart, 0);
    check("rst_end", oEnd, 0);
    check("rst_key_ready", oKey_ready, 0);
    check("rst_busy", oBusy, 0);
    iRst = 1'b0;
    @(posedge iClk);
    #1;

    // Message beat with no key is ignored.
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h3);
    check("nokey_msg_valid", oValid, 0);

    // Reset in the middle of a key load.
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'hA);
    check("partial_key_ready", oKey_ready, 0);
    iEn = 1'b0; iLoad_key = 1'b0;
    #2 iRst = 1'b1;
    #1;
    check("midrst_valid", oValid, 0);
    check("midrst_data", oData, 0);
    check("midrst_key_ready", oKey_ready, 0);
    check("midrst_busy", oBusy, 0);
    #2 iRst = 1'b0;
    @(posedge iClk);
    #1;
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h1);
    check("postrst_msg_valid", oValid, 0);
    check("postrst_key_ready", oKey_ready, 0);

    // Plain, roll, then plain again from the unrotated key.
    loadKey(8'hA5);
    sendMsg(32'h12345678, 32'hB791F3DD, 1'b0, 8'h00, 1'b0);
    sendMsg(32'h12345678, 32'hB77FC055, 1'b1, 8'h00, 1'b0);
    sendMsg(32'h12345678, 32'hB791F3DD, 1'b0, 8'h00, 1'b0);

    // Random gaps, then a back-to-back message.
    sendMsg(32'h12345678, 32'hB791F3DD, 1'b0, 8'($urandom_range(1, 255)), 1'b0);
    sendMsg(32'h87654321, 32'h22C0E684, 1'b0, 8'h00, 1'b0);

    // Abort after three roll-mode beats; the next message starts from key_reg.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'(i + 1));
      check("abort_pre_valid", oValid, 1);
    end
    check("abort_pre_data", oData, 4'h7);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    check("abort_valid", oValid, 0);
    check("abort_end", oEnd, 0);
    check("abort_busy", oBusy, 0);
    sendMsg(32'h87654321, 32'h22C0E684, 1'b0, 8'h00, 1'b0);

    // Both flags in READY: key wins.
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h3);
    check("prio_ready_key_ready", oKey_ready, 0);
    check("prio_ready_valid", oValid, 0);
    check("prio_ready_busy", oBusy, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'hC);
    check("prio_newkey_ready", oKey_ready, 1);
    sendMsg(32'h12345678, 32'h2E086A44, 1'b0, 8'h00, 1'b0);

    // Both flags mid-STREAM: message wins, key untouched.
    sendMsg(32'h12345678, 32'h2E086A44, 1'b0, 8'h00, 1'b1);
    check("prio_stream_key_ready", oKey_ready, 1);
    sendMsg(32'h12345678, 32'h2E086A44, 1'b0, 8'h00, 1'b0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    check("final_idle_valid", oValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
